// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game body logic and its consumers.
package snake_pkg;

    localparam int COORD_W  = 4;
    localparam int MAX_LEN  = 50;
    localparam int INIT_LEN = 3;
    localparam int LEN_W    = 6;

    typedef enum logic [1:0] {
        UP    = 2'b00,
        DOWN  = 2'b01,
        LEFT  = 2'b10,
        RIGHT = 2'b11
    } dir_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } coord_t;

    localparam coord_t INIT_HEAD = 8'h48;

    function automatic dir_t opposite(input dir_t d);
        case (d)
            UP:      return DOWN;
            DOWN:    return UP;
            LEFT:    return RIGHT;
            default: return LEFT;
        endcase
    endfunction

    // Initial snake lies on the head row, tail extending toward smaller x.
    function automatic coord_t init_entry(input int i);
        coord_t c;
        c.x = COORD_W'(int'(INIT_HEAD.x) - i);
        c.y = INIT_HEAD.y;
        return c;
    endfunction

endpackage

// File: rtl/snake_body_if.sv
// Body/apple link between the snake body (producer) and the apple generator.
interface snake_body_if;
    import snake_pkg::*;

    coord_t [MAX_LEN-1:0] body;
    logic                 goodColl;
    coord_t               apple_cord;

    modport master (output body, output goodColl, input apple_cord);
    modport slave  (input body, input goodColl, output apple_cord);

endinterface

// File: rtl/snake_next_head.sv
// Combinational next-head calculator; SNAKE_WRAP_EN makes the grid a torus.
module snake_next_head
    import snake_pkg::*;
(
    input  coord_t head,
    input  dir_t   dir,
    output coord_t next_head,
    output logic   wall
);

    logic at_edge;

    // 4-bit arithmetic wraps naturally; the edge flag decides whether that is legal.
    always_comb begin
        next_head = head;
        at_edge   = 1'b0;
        case (dir)
            UP: begin
                next_head.y = head.y - 1'b1;
                at_edge     = (head.y == '0);
            end
            DOWN: begin
                next_head.y = head.y + 1'b1;
                at_edge     = &head.y;
            end
            LEFT: begin
                next_head.x = head.x - 1'b1;
                at_edge     = (head.x == '0);
            end
            default: begin
                next_head.x = head.x + 1'b1;
                at_edge     = &head.x;
            end
        endcase
    end

`ifdef SNAKE_WRAP_EN
    assign wall = 1'b0;
`else
    assign wall = at_edge;
`endif

endmodule

// File: rtl/snake_body.sv
// Snake segment list, movement/growth, collision FSM and pixel flags.
// Optional SNAKE_WRAP_EN (in snake_next_head) replaces wall death with wrap-around.
module snake_body
    import snake_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               step,
    input  logic [1:0]         dir,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    snake_body_if.master       bus,
    output logic [LEN_W-1:0]   length,
    output logic               badColl,
    output logic               head,
    output logic               snakeBody
);

    typedef enum logic {RUN, DEAD} state_t;

    state_t             state, next_state;
    dir_t               cur_dir, req_dir, accepted_dir;
    coord_t             nh, scan;
    logic               wall, grow, self_hit, body_hit, move, die;
    logic [LEN_W-1:0]   new_len;

    assign req_dir      = dir_t'(dir);
    assign accepted_dir = (req_dir == opposite(cur_dir)) ? cur_dir : req_dir;
    assign scan         = {x, y};

    snake_next_head u_next_head (
        .head      (bus.body[0]),
        .dir       (accepted_dir),
        .next_head (nh),
        .wall      (wall)
    );

    assign grow    = (nh == bus.apple_cord) && !wall;
    assign new_len = (grow && (int'(length) < MAX_LEN)) ? length + 1'b1 : length;

    // The tail vacates its cell on a plain move, so it only blocks when growing.
    always_comb begin
        self_hit = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((bus.body[i] == nh) &&
                ((i < int'(length) - 1) || (grow && (i == int'(length) - 1))))
                self_hit = 1'b1;
        end
    end

    always_comb begin
        body_hit = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((i < int'(length)) && (bus.body[i] == scan))
                body_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= RUN;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        move       = 1'b0;
        die        = 1'b0;
        if ((state == RUN) && step) begin
            if (wall || self_hit) begin
                next_state = DEAD;
                die        = 1'b1;
            end else begin
                move = 1'b1;
            end
        end
    end

    // Unused tail slots track the head so downstream full-array compares stay harmless.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_dir      <= RIGHT;
            length       <= LEN_W'(INIT_LEN);
            bus.goodColl <= 1'b0;
            badColl      <= 1'b0;
            head         <= 1'b0;
            snakeBody    <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++)
                bus.body[i] <= (i < INIT_LEN) ? init_entry(i) : INIT_HEAD;
        end else begin
            bus.goodColl <= move && grow;
            if (die)
                badColl <= 1'b1;
            if ((state == RUN) && step)
                cur_dir <= accepted_dir;
            if (move) begin
                length      <= new_len;
                bus.body[0] <= nh;
                for (int i = 1; i < MAX_LEN; i++)
                    bus.body[i] <= (i < int'(new_len)) ? bus.body[i-1] : nh;
            end
            head      <= (scan == bus.body[0]);
            snakeBody <= body_hit;
        end
    end

endmodule

// File: tb/tb_snake_body.sv
// Directed self-checking bench for snake_body with hand-computed expectations.
module tb_snake_body;
    import snake_pkg::*;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               step = 1'b0;
    logic [1:0]         dir = 2'b11;
    logic [COORD_W-1:0] x = '0;
    logic [COORD_W-1:0] y = '0;
    logic [LEN_W-1:0]   length;
    logic               badColl, head, snakeBody;
    int                 checkCount = 0;
    int                 passCount = 0;

    snake_body_if bus ();

    snake_body dut (
        .clk       (clk),
        .reset     (reset),
        .step      (step),
        .dir       (dir),
        .x         (x),
        .y         (y),
        .bus       (bus.master),
        .length    (length),
        .badColl   (badColl),
        .head      (head),
        .snakeBody (snakeBody)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected)
            passCount++;
        else
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    endtask

    // n back-to-back step pulses; returns on the negedge right after the last one.
    task automatic applyStimulus(input logic [1:0] d, input int n);
        @(negedge clk);
        step = 1'b1;
        dir  = d;
        repeat (n) @(negedge clk);
        step = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        bus.apple_cord = 8'h00;
        doReset();

        checkOutput("rst_len", length, 3);
        checkOutput("rst_b0", bus.body[0], 8'h48);
        checkOutput("rst_b1", bus.body[1], 8'h38);
        checkOutput("rst_b2", bus.body[2], 8'h28);
        checkOutput("rst_b3", bus.body[3], 8'h48);
        checkOutput("rst_b49", bus.body[49], 8'h48);
        checkOutput("rst_good", bus.goodColl, 0);
        checkOutput("rst_bad", badColl, 0);
        checkOutput("rst_head", head, 0);
        checkOutput("rst_sbody", snakeBody, 0);

        // three moves right, goodColl must never fire
        for (int s = 0; s < 3; s++) begin
            applyStimulus(2'b11, 1);
            checkOutput($sformatf("mv_good%0d", s), bus.goodColl, 0);
        end
        checkOutput("mv_b0", bus.body[0], 8'h78);
        checkOutput("mv_b1", bus.body[1], 8'h68);
        checkOutput("mv_b2", bus.body[2], 8'h58);
        checkOutput("mv_len", length, 3);
        for (int i = 3; i < MAX_LEN; i++)
            checkOutput($sformatf("mv_b%0d", i), bus.body[i], 8'h78);

        // eat apple directly ahead
        doReset();
        bus.apple_cord = 8'h58;
        applyStimulus(2'b11, 1);
        checkOutput("eat_good", bus.goodColl, 1);
        checkOutput("eat_len", length, 4);
        checkOutput("eat_b0", bus.body[0], 8'h58);
        checkOutput("eat_b1", bus.body[1], 8'h48);
        checkOutput("eat_b2", bus.body[2], 8'h38);
        checkOutput("eat_b3", bus.body[3], 8'h28);
        checkOutput("eat_b4", bus.body[4], 8'h58);
        checkOutput("eat_b49", bus.body[49], 8'h58);
        @(negedge clk);
        checkOutput("eat_good_pulse", bus.goodColl, 0);

        // reverse request ignored
        doReset();
        bus.apple_cord = 8'h00;
        applyStimulus(2'b10, 1);
        checkOutput("rev_b0", bus.body[0], 8'h58);
        checkOutput("rev_bad", badColl, 0);

        // run into the right wall
        doReset();
        applyStimulus(2'b11, 11);
        checkOutput("wall_pre", bus.body[0], 8'hF8);
        applyStimulus(2'b11, 1);
`ifdef SNAKE_WRAP_EN
        checkOutput("wrap_b0", bus.body[0], 8'h08);
        checkOutput("wrap_bad", badColl, 0);
        applyStimulus(2'b01, 1);
        checkOutput("wrap_b0_2", bus.body[0], 8'h09);
`else
        checkOutput("wall_bad", badColl, 1);
        checkOutput("wall_b0", bus.body[0], 8'hF8);
        checkOutput("wall_len", length, 3);
        applyStimulus(2'b01, 1);
        checkOutput("dead_b0", bus.body[0], 8'hF8);
        checkOutput("dead_bad", badColl, 1);
`endif
        // reset asserted mid-cycle clears everything at once
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checkOutput("arst_bad", badColl, 0);
        checkOutput("arst_len", length, 3);
        checkOutput("arst_b0", bus.body[0], 8'h48);
        @(negedge clk);
        reset = 1'b1;

        // grow to 5 then turn into own body
        doReset();
        bus.apple_cord = 8'h58;
        applyStimulus(2'b11, 1);
        bus.apple_cord = 8'h68;
        applyStimulus(2'b11, 1);
        bus.apple_cord = 8'h00;
        checkOutput("g5_len", length, 5);
        applyStimulus(2'b01, 1);
        applyStimulus(2'b10, 1);
        checkOutput("g5_b0", bus.body[0], 8'h59);
        checkOutput("g5_bad_pre", badColl, 0);
        applyStimulus(2'b00, 1);
        checkOutput("self_bad", badColl, 1);
        checkOutput("self_b0", bus.body[0], 8'h59);
        checkOutput("self_len", length, 5);

        // stepping onto the vacating tail is legal
        doReset();
        bus.apple_cord = 8'h58;
        applyStimulus(2'b11, 1);
        bus.apple_cord = 8'h00;
        applyStimulus(2'b01, 1);
        applyStimulus(2'b10, 1);
        applyStimulus(2'b00, 1);
        checkOutput("tail_bad", badColl, 0);
        checkOutput("tail_b0", bus.body[0], 8'h48);
        checkOutput("tail_b3", bus.body[3], 8'h58);
        checkOutput("tail_len", length, 4);

        // same cell, but an apple there keeps the tail in place -> death
        doReset();
        bus.apple_cord = 8'h58;
        applyStimulus(2'b11, 1);
        bus.apple_cord = 8'h00;
        applyStimulus(2'b01, 1);
        applyStimulus(2'b10, 1);
        bus.apple_cord = 8'h48;
        applyStimulus(2'b00, 1);
        checkOutput("tailg_bad", badColl, 1);
        checkOutput("tailg_good", bus.goodColl, 0);
        checkOutput("tailg_b0", bus.body[0], 8'h49);

        // pixel flags
        doReset();
        bus.apple_cord = 8'h00;
        x = 4'd4; y = 4'd8;
        @(negedge clk);
        checkOutput("pix_head", head, 1);
        checkOutput("pix_head_sb", snakeBody, 0);
        x = 4'd3;
        @(negedge clk);
        checkOutput("pix_sb", snakeBody, 1);
        checkOutput("pix_sb_head", head, 0);
        x = 4'd2;
        @(negedge clk);
        checkOutput("pix_tail", snakeBody, 1);
        x = 4'd1;
        @(negedge clk);
        checkOutput("pix_none", snakeBody, 0);

        // reset during a step that would have eaten: no pulse
        bus.apple_cord = 8'h58;
        @(negedge clk);
        step = 1'b1;
        dir  = 2'b11;
        #2 reset = 1'b0;
        @(negedge clk);
        step = 1'b0;
        checkOutput("rstep_good", bus.goodColl, 0);
        checkOutput("rstep_b0", bus.body[0], 8'h48);
        checkOutput("rstep_len", length, 3);
        reset = 1'b1;

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/snake_body.md
Name: snake_body

Overview:
- Owns the snake: maintains the segment coordinate list, advances it on each game tick and grows it when the head reaches the apple.
- Is the producer end of the body/goodColl interface consumed by the apple generator: drives `body` and the one-cycle `goodColl` pulse.
- Also supplies registered head/body pixel flags to the display path for the current scan coordinate.

Parameters:
- MAX_LEN, 50: number of body entries; must match the apple generator's body array depth.
- INIT_LEN, 3: segment count after reset; legal range 2..MAX_LEN.
- COORD_W, 4: bits per axis; grid is 2^COORD_W square (16x16).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset (acts on negedge reset).
- step  input  1  one-cycle movement tick from the game-speed counter.
- dir  input  2  requested direction: 00 up (y-1), 01 down (y+1), 10 left (x-1), 11 right (x+1).
- apple_cord  input  8  current apple {ax, ay}.
- x  input  4  scan column.
- y  input  4  scan row.
- body  output  MAX_LEN x 8  segment list {sx, sy}; index 0 is the head.
- length  output  6  active segment count.
- goodColl  output  1  one-cycle pulse: the head just landed on the apple.
- badColl  output  1  sticky flag: wall or self collision; game over.
- head  output  1  registered flag: (x,y) equals body[0].
- snakeBody  output  1  registered flag: (x,y) equals any active segment at index >= 1.

Behaviour:
- States: RUN and DEAD.
- Reset values:
  - State RUN; cur_dir right.
  - length = INIT_LEN.
  - body[i] = {4-i, 8} for i < INIT_LEN, so the head is (4,8) and the tail extends leftward.
  - Every entry at index >= length holds the head coordinate. This invariant holds at all times, so the apple generator's full-array compare never blocks a free cell.
  - goodColl = 0, badColl = 0, head = 0, snakeBody = 0.
- Direction:
  - dir is sampled only on a step cycle in RUN.
  - A request exactly opposite cur_dir is ignored and cur_dir is kept.
  - Otherwise cur_dir is set to dir.
- Next head: computed combinationally from body[0] and the accepted direction.
- Wall hit: the move would leave the grid (x=0 moving left, x=15 moving right, y=0 moving up, y=15 moving down).
- Grow: next head == apple_cord and no wall hit.
- Self hit: next head equals body[i] for any 1 <= i < length-1. The tail (index length-1) is also checked when grow=1, because the tail does not vacate that cycle.
- Step in RUN at cycle N, with all results registered at N+1:
  - Wall or self hit: state becomes DEAD, badColl=1, body and length frozen, goodColl stays 0. Wall takes priority over grow.
  - Otherwise: body[i] <= body[i-1] for 1 <= i < MAX_LEN, and body[0] <= next head.
  - If grow=1 and length < MAX_LEN: length increments by 1. The new tail entry is the old tail, retained by the shift.
  - If grow=1 and length == MAX_LEN: length saturates at MAX_LEN.
  - Entries at index >= new length are rewritten to the new head coordinate.
  - goodColl=1 for exactly the N+1 cycle whenever grow=1, including at saturation.
- step in DEAD is ignored; only reset leaves DEAD.
- step on consecutive cycles: each one is processed; no minimum spacing.
- Pixel flags: head and snakeBody are registered one cycle after x,y. They stay live in DEAD so the frozen snake remains drawn.
- Reset asserted mid-step: all state returns to the reset values immediately; no goodColl pulse is emitted.

Optional Feature:
- Macro SNAKE_WRAP_EN.
- Defined: wall hits are disabled. Coordinates wrap modulo 16 (x=15 moving right becomes 0, y=0 moving up becomes 15, etc.). Only self hits set badColl.
- Undefined: wall behaviour exactly as described in Behaviour.

Decomposition:
- snake_pkg:
  - dir_t enum (UP, DOWN, LEFT, RIGHT).
  - coord_t (8-bit packed {x,y}).
  - MAX_LEN, INIT_LEN, INIT_HEAD = 8'h48.
  - function opposite(dir_t).
- Sub-module snake_next_head: combinational. Inputs are head and dir_t; outputs are next head and wall flag; contains the SNAKE_WRAP_EN logic.
- The shift register, collision compare and FSM stay in snake_body.

Test Plan:
- Reset, then 3 steps with dir=11 -> body[0]=8'h78, body[1]=8'h68, body[2]=8'h58; length=3; entries 3..49 = 8'h78; goodColl never asserted.
- apple_cord=8'h58 from reset, step with dir=11 -> next cycle: goodColl=1 for one cycle, length=4, body[0..3]=58,48,38,28, body[4..49]=58.
- From reset (heading right), step with dir=10 (reverse) -> request ignored; body[0]=8'h58.
- Head at 8'hF8 moving right, step -> badColl=1, body unchanged on later steps. With SNAKE_WRAP_EN: body[0]=8'h08, badColl=0.
- Grow to length 5, then steer down, left, up into the 2nd segment -> badColl=1 on the cycle after the fatal step. Repeat with the collision cell equal to the tail while not growing -> no badColl.
- Scan x=4, y=8 after reset -> head=1, snakeBody=0 one cycle later. Scan x=3, y=8 -> snakeBody=1. Assert reset mid-run -> length=3, badColl=0 immediately.
